// File: rtl/vc_test_src_arb.sv
// vc_test_src_arb
//   Round-robin arbiter that merges p_nreqs val/rdy message streams onto a
//   single registered output channel. Each output message carries the index
//   of the source that supplied it. The block also combines the per-source
//   done flags into one harness-level done.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   in_val/in_rdy      per-requester handshake (in_rdy is one-hot or zero)
//   in_msg             flattened messages, requester i at [i*p_msg_nbits +: p_msg_nbits]
//   in_done            per-requester "all messages issued"
//   out_val/out_rdy    registered output handshake
//   out_msg, out_id    registered output message and its source index
//   done               all sources done and the output buffer empty
//   timeout            sticky stall watchdog flag
//
// Optional feature: define VC_TEST_SRC_ARB_TIMEOUT_EN to build the stall
// watchdog. Without it, timeout is tied to 0.
module vc_test_src_arb #(
  parameter int p_msg_nbits = 32,
  parameter int p_nreqs     = 4,
  parameter int p_id_nbits  = 2,
  parameter int p_timeout   = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             in_val,
  output logic [p_nreqs-1:0]             in_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
  input  logic [p_nreqs-1:0]             in_done,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic [p_id_nbits-1:0]          out_id,
  output logic                           done,
  output logic                           timeout
);

  // Elaboration-time parameter sanity checks.
  if (p_nreqs < 2 || p_nreqs > 8) begin : g_bad_nreqs
    $error("vc_test_src_arb: p_nreqs must be in 2..8");
  end
  if ((1 << p_id_nbits) < p_nreqs) begin : g_bad_id
    $error("vc_test_src_arb: p_id_nbits too small for p_nreqs");
  end
  if (p_timeout < 1) begin : g_bad_timeout
    $error("vc_test_src_arb: p_timeout must be positive");
  end

  localparam logic [p_id_nbits:0] NREQS = (p_id_nbits+1)'(p_nreqs);

  logic [p_id_nbits-1:0]  ptr_q, ptr_d;
  logic                   out_val_q, out_val_d;
  logic [p_msg_nbits-1:0] out_msg_q, out_msg_d;
  logic [p_id_nbits-1:0]  out_id_q, out_id_d;
  logic                   done_q, done_d;

  logic [2*p_nreqs-1:0]   val_dbl;
  logic [2*p_nreqs-1:0]   val_rot;
  logic [p_id_nbits-1:0]  grant;
  logic [p_id_nbits:0]    idx_sum;
  logic [p_id_nbits:0]    ptr_sum;
  logic                   any_val;
  logic                   load;
  logic                   in_hs;
  logic                   out_hs;
  logic [p_msg_nbits-1:0] grant_msg;
  logic [p_nreqs-1:0]     grant_oh;

  // Rotate the request vector so bit 0 is the requester at ptr; the first
  // set bit k of the rotated vector then maps back to (ptr + k) mod p_nreqs.
  always_comb begin
    val_dbl = {in_val, in_val};
    val_rot = val_dbl >> ptr_q;
    any_val = |in_val;
    grant   = '0;
    idx_sum = '0;
    for (int k = p_nreqs - 1; k >= 0; k--) begin
      if (val_rot[k]) begin
        idx_sum = {1'b0, ptr_q} + (p_id_nbits+1)'(k);
        if (idx_sum >= NREQS) idx_sum = idx_sum - NREQS;
        grant = idx_sum[p_id_nbits-1:0];
      end
    end
  end

  always_comb begin
    grant_msg = '0;
    grant_oh  = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      if (grant == p_id_nbits'(i)) begin
        grant_msg   = in_msg[i*p_msg_nbits +: p_msg_nbits];
        grant_oh[i] = 1'b1;
      end
    end
  end

  // in_rdy is suppressed during reset so nothing appears accepted while the
  // buffer is being cleared.
  assign load   = !out_val_q || out_rdy;
  assign in_hs  = !reset && load && any_val;
  assign out_hs = out_val_q && out_rdy;
  assign in_rdy = in_hs ? grant_oh : '0;

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_id_d  = out_id_q;
    ptr_d     = ptr_q;
    ptr_sum   = {1'b0, grant} + (p_id_nbits+1)'(1);
    if (in_hs) begin
      out_val_d = 1'b1;
      out_msg_d = grant_msg;
      out_id_d  = grant;
      ptr_d     = (ptr_sum == NREQS) ? '0 : ptr_sum[p_id_nbits-1:0];
    end else if (load) begin
      out_val_d = 1'b0;
    end
    done_d = (&in_done) && !out_val_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_id_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_id_q  <= out_id_d;
      done_q    <= done_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_id  = out_id_q;
  assign done    = done_q;

`ifdef VC_TEST_SRC_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;

  // Counter saturates rather than wrapping so a very long stall cannot
  // look like progress.
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (in_hs || out_hs) begin
      wd_cnt_d = '0;
    end else if ((out_val_q && !out_rdy) || !done_q) begin
      if (wd_cnt_q != '1) wd_cnt_d = wd_cnt_q + 32'd1;
    end
    if (wd_cnt_d >= 32'(p_timeout)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_vc_test_src_arb.sv
module tb_vc_test_src_arb;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     in_val = '0;
  logic [N-1:0]     in_rdy;
  logic [N*W-1:0]   in_msg = '0;
  logic [N-1:0]     in_done = '0;
  logic             out_val;
  logic             out_rdy = 1'b0;
  logic [W-1:0]     out_msg;
  logic [IDW-1:0]   out_id;
  logic             done;
  logic             timeout;

  vc_test_src_arb #(
    .p_msg_nbits(W), .p_nreqs(N), .p_id_nbits(IDW), .p_timeout(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg), .in_done(in_done),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_id(out_id),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one-entry buffer, priority pointer, done, watchdog.
  int          m_ptr, m_id, m_cnt;
  bit          m_val, m_done, m_to;
  logic [W-1:0] m_msg;
  logic [N-1:0] last_er;
  logic [W-1:0] out_log[$];

  function automatic int grant_of();
    int g = -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (g < 0 && in_val[i]) g = i;
    end
    return g;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_id = 0; m_cnt = 0;
    m_val = 0; m_done = 0; m_to = 0; m_msg = '0;
  endtask

  task automatic set_msg(input int i, input logic [W-1:0] v);
    in_msg[i*W +: W] = v;
  endtask

  // Inputs must already be set; checks in_rdy before the edge and all
  // registered outputs after it.
  task automatic cycle();
    int g;
    bit ld, ihs, ohs;
    logic [N-1:0] er;
    #1;
    g  = grant_of();
    ld = !m_val || out_rdy;
    er = '0;
    if (!reset && ld && g >= 0) er[g] = 1'b1;
    last_er = er;
    chk("in_rdy", 64'(in_rdy), 64'(er));
    ihs = (er != 0);
    ohs = m_val && out_rdy;
    if (!reset && out_val && out_rdy) out_log.push_back(out_msg);
    @(posedge clk);
    #1;
    if (reset) begin
      model_clear();
    end else begin
      if (ihs || ohs) m_cnt = 0;
      else if ((m_val && !out_rdy) || !m_done) m_cnt++;
      if (ld) begin
        if (g >= 0) begin
          m_val = 1; m_msg = in_msg[g*W +: W]; m_id = g; m_ptr = (g + 1) % N;
        end else begin
          m_val = 0;
        end
      end
      m_done = (&in_done) && !m_val;
      if (m_cnt >= TO) m_to = 1;
    end
    chk("out_val", 64'(out_val), 64'(m_val));
    if (m_val) begin
      chk("out_msg", 64'(out_msg), 64'(m_msg));
      chk("out_id", 64'(out_id), 64'(m_id));
    end
    chk("done", 64'(done), 64'(m_done));
`ifdef VC_TEST_SRC_ARB_TIMEOUT_EN
    chk("timeout", 64'(timeout), 64'(m_to));
`else
    chk("timeout", 64'(timeout), 64'd0);
`endif
  endtask

  // Raise reset away from any clock edge and check the async clear at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_msg", 64'(out_msg), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic randomize_inputs();
    in_val = N'($urandom);
    for (int i = 0; i < N; i++) set_msg(i, $urandom);
    out_rdy = ($urandom_range(0, 3) != 0);
    in_done = ($urandom_range(0, 7) != 0) ? '1 : N'($urandom);
  endtask

  initial begin
    model_clear();
    last_er = '0;
    #3;
    do_reset();

    // Random traffic before the mid-cycle reset.
    for (int c = 0; c < 40; c++) begin
      randomize_inputs();
      cycle();
    end
    randomize_inputs();
    do_reset();

    // Full contention: grants rotate starting at requester 0.
    in_val = '1; out_rdy = 1'b1; in_done = '0;
    for (int i = 0; i < N; i++) set_msg(i, W'(32'hA0 + i));
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_id", 64'(out_id), 64'(k % N));
      chk("rr_msg", 64'(out_msg), 64'(32'hA0 + (k % N)));
      chk("rr_val", 64'(out_val), 64'd1);
    end

    // Back-pressure: buffer 0xA2, stall 5 cycles, next grant is 3.
    do_reset();
    in_val = 4'b0100; out_rdy = 1'b1;
    cycle();
    chk("bp_load", 64'(out_msg), 64'hA2);
    in_val = '1; out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_rdy", 64'(last_er), 64'd0);
      chk("bp_msg", 64'(out_msg), 64'hA2);
    end
    out_rdy = 1'b1;
    cycle();
    chk("bp_next_id", 64'(out_id), 64'd3);
    chk("bp_next_msg", 64'(out_msg), 64'hA3);

    // Sparse traffic from requester 2 with random sink readiness.
    do_reset();
    out_log.delete();
    begin
      int nxt = 1;
      int budget = 200;
      while (out_log.size() < 10 && budget > 0) begin
        in_val = (nxt <= 10) ? 4'b0100 : 4'b0000;
        set_msg(2, W'(nxt));
        out_rdy = ($urandom_range(0, 1) == 1);
        cycle();
        if (last_er[2]) nxt++;
        budget--;
      end
      chk("sparse_budget", 64'(budget > 0), 64'd1);
      chk("sparse_count", 64'(out_log.size()), 64'd10);
      for (int i = 0; i < out_log.size() && i < 10; i++)
        chk("sparse_order", 64'(out_log[i]), 64'(i + 1));
    end

    // Done aggregation around one buffered message.
    do_reset();
    in_done = '0; in_val = 4'b0010; set_msg(1, 32'h55); out_rdy = 1'b0;
    cycle();
    in_val = '0; in_done = '1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("done_held", 64'(done), 64'd0);
    end
    out_rdy = 1'b1;
    cycle();
    chk("done_set", 64'(done), 64'd1);
    in_done = 4'b1011;
    cycle();
    chk("done_drop", 64'(done), 64'd0);

`ifdef VC_TEST_SRC_ARB_TIMEOUT_EN
    // Watchdog: one buffered message stalled for TO cycles.
    do_reset();
    in_done = '0; in_val = 4'b0010; set_msg(1, 32'h77); out_rdy = 1'b0;
    cycle();
    in_val = '0;
    for (int k = 1; k <= TO; k++) begin
      cycle();
      if (k == TO - 1) chk("wd_before", 64'(timeout), 64'd0);
    end
    chk("wd_fire", 64'(timeout), 64'd1);
    out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    chk("wd_sticky", 64'(timeout), 64'd1);
    do_reset();
    chk("wd_cleared", 64'(timeout), 64'd0);
`endif

    // Long randomized run against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vc_test_src_arb.md
# vc_test_src_arb

Round-robin arbiter for test harnesses: merges `p_nreqs` val/rdy message streams, typically random-delay test sources, onto one registered output channel. Each output message is tagged with the index of the source it came from. The block also aggregates the sources' `done` flags into one harness-level `done`. It sits between a bank of test sources and a single sink or DUT input port, so a bench can share one port among several independent stimulus streams.

## Interface
Parameters:
- `p_msg_nbits`, 32, message width in bits
- `p_nreqs`, 4, number of requesters; legal range 2..8
- `p_id_nbits`, 2, width of the source tag; must satisfy 2^`p_id_nbits` >= `p_nreqs`
- `p_timeout`, 1024, stall-cycle limit for the watchdog (used only when the watchdog is compiled in)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_val`  in  `p_nreqs`  per-requester valid
- `in_rdy`  out  `p_nreqs`  per-requester ready; one-hot or zero
- `in_msg`  in  `p_nreqs*p_msg_nbits`  flattened messages; requester i occupies bits [i*`p_msg_nbits` +: `p_msg_nbits`]
- `in_done`  in  `p_nreqs`  per-requester "all messages issued" flag
- `out_val`  out  1  output valid (registered)
- `out_rdy`  in  1  output ready from sink
- `out_msg`  out  `p_msg_nbits`  output message (registered)
- `out_id`  out  `p_id_nbits`  index of the source that supplied `out_msg` (registered)
- `done`  out  1  all sources done and output buffer empty
- `timeout`  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out

## Operation
- **Output buffer:** one entry holding `out_val`, `out_msg` and `out_id`.
  - `load = !out_val || out_rdy`; the buffer may accept a new message when empty or draining in the same cycle.
- **Priority pointer:** `ptr`, range 0..`p_nreqs`-1.
  - Grant `g` is the first i with `in_val[i]`, searching `ptr`, `ptr`+1, … and wrapping modulo `p_nreqs`.
- **Ready:** `in_rdy[g] = load`; every other `in_rdy` bit is 0. `in_rdy` is combinational from `in_val`, `out_val`, `out_rdy` and `ptr`.
- **On a granted handshake** (`in_val[g] && in_rdy[g]`):
  - `out_msg <= in_msg[g]`, `out_id <= g`, `out_val <= 1`.
  - `ptr <= (g+1) mod p_nreqs`.
- **Drain with no replacement:** when `load` is true, `out_val` is 1 and no `in_val` is set, `out_val <= 0`. `out_msg` and `out_id` hold their values.
- **No request:** `ptr` is unchanged when there is no grant.
- **Done:** `done` is registered: `done <= &in_done && !next_out_val`. It deasserts if any `in_done` falls.
- **No drops, no duplicates:** every input handshake produces exactly one output handshake. Messages from one source leave in that source's order.

## Timing
- **Reset values:** while `reset` is high, and asynchronously on its rise:
  - `out_val`, `out_msg`, `out_id`, `done`, `timeout` = 0.
  - `ptr` = 0, so requester 0 has first priority.
  - watchdog counter = 0.
- **Latency:** an input handshake in cycle N gives `out_val` = 1 in cycle N+1.
- **Throughput:** one message per cycle when `out_rdy` is held high.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,`p_nreqs`-1,0,… Each requester waits at most `p_nreqs`-1 grants.
- **Back-pressure:** while `out_val && !out_rdy`, all `in_rdy` are 0 and the output register is stable.
- **Single requester:** a lone active requester is granted every eligible cycle regardless of `ptr`.
- **Reset mid-transfer:** a buffered message is discarded; no output handshake occurs for it.

## Configuration
- Macro: `VC_TEST_SRC_ARB_TIMEOUT_EN`.
- **Defined:** a 32-bit stall counter.
  - Increments on each cycle with `out_val && !out_rdy`, or with `!done` and no input handshake.
  - Clears on any input or output handshake.
  - When the counter reaches `p_timeout`, `timeout` is set and stays at 1 until reset.
  - The flag is purely observational; arbitration is unchanged.
- **Undefined:** no counter is built and `timeout` is tied to 0.

## Test plan
- **Reset state:** assert `reset` mid-cycle with arbitrary inputs. Required: `out_val`, `out_id`, `done`, `timeout` = 0 immediately and `in_rdy` = 0; after release, requester 0 wins a full-contention first cycle.
- **Full contention:** `p_nreqs`=4, all `in_val`=1, `in_msg[i]`=0xA0+i, `out_rdy`=1. Required: `out_id` sequence 0,1,2,3,0,1 with `out_msg` 0xA0,0xA1,0xA2,0xA3,0xA0,0xA1, one per cycle, starting one cycle after the first handshake.
- **Back-pressure:** load 0xA2, then hold `out_rdy`=0 for 5 cycles. Required: `out_msg`=0xA2 stable, `in_rdy`=0000 throughout; after release the next grant is requester 3.
- **Sparse traffic:** only requester 2 valid, messages 1..10, random `out_rdy`. Required: output order 1..10, all with `out_id`=2, no duplicates.
- **Done aggregation:** all `in_done`=1 while one message is buffered and `out_rdy`=0. Required: `done`=0 until the cycle after that message drains, then `done`=1.
- **Watchdog (macro defined, `p_timeout`=16):** one buffered message with `out_rdy`=0. Required: `timeout`=1 after 16 stall cycles, still 1 after `out_rdy` returns, cleared only by `reset`. With the macro undefined, `timeout` stays 0.
